// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding, byte-count constant and byte-lane merge helper for sram_ctrl.
package sram_ctrl_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_RSP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        RD   = ST_RD,
        WR   = ST_WR,
        HOLD = ST_HOLD,
        RSP  = ST_RSP
    } state_t;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int BYTE_COUNT         = DATA_WIDTH_DEFAULT / 8;

    // One byte lane of a read-modify-write: enabled lanes take the new byte.
    function automatic logic [7:0] be_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Request/response front end for an asynchronous SRAM: sequences cs/wr/addr/din,
// waits WAIT_CYCLES per access and performs byte-masked writes by read-modify-write.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    sram_cs,
    output logic                    sram_wr,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_din,
    input  logic [DATA_WIDTH-1:0]   sram_dout
);

    localparam int                   BE_WIDTH  = DATA_WIDTH / 8;
    localparam int                   CNT_WIDTH = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD  = CNT_WIDTH'(WAIT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t                  state_reg, state_next;
    logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
    logic                    we_reg, we_next;
    logic [BE_WIDTH-1:0]     be_reg, be_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic                    cs_reg, cs_next;
    logic                    wr_reg, wr_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   din_reg, din_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic [DATA_WIDTH-1:0]   merged_word;

    // Old word straight from the SRAM, overlaid lane by lane with the latched write data.
    genvar gi;
    generate
        for (gi = 0; gi < BE_WIDTH; gi++) begin : g_merge
            assign merged_word[8*gi +: 8] = be_merge(sram_dout[8*gi +: 8],
                                                     wdata_reg[8*gi +: 8],
                                                     be_reg[gi]);
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        we_next        = we_reg;
        be_next        = be_reg;
        wdata_next     = wdata_reg;
        cs_next        = cs_reg;
        wr_next        = wr_reg;
        addr_next      = addr_reg;
        din_next       = din_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    we_next    = req_we;
                    be_next    = req_be;
                    wdata_next = req_wdata;
                    if (!req_we || (req_be != '0 && !(&req_be))) begin
                        // Plain read, or the read half of a partial write.
                        state_next = RD;
                        cs_next    = 1'b1;
                        wr_next    = 1'b0;
                        addr_next  = req_addr;
                        cnt_next   = CNT_LOAD;
                    end else if (req_be == '0) begin
                        state_next     = RSP;
                        rsp_valid_next = 1'b1;
                        rsp_rdata_next = '0;
                    end else begin
                        state_next = WR;
                        cs_next    = 1'b1;
                        wr_next    = 1'b1;
                        addr_next  = req_addr;
                        din_next   = req_wdata;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end

            RD: begin
                if (cnt_reg == '0) begin
                    if (we_reg) begin
                        // cs stays high; din is updated while wr is still low.
                        state_next = WR;
                        wr_next    = 1'b1;
                        din_next   = merged_word;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        state_next     = RSP;
                        cs_next        = 1'b0;
                        rsp_valid_next = 1'b1;
                        rsp_rdata_next = sram_dout;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            WR: begin
                if (cnt_reg == '0) begin
                    state_next = HOLD;
                    cs_next    = 1'b0;
                    wr_next    = 1'b0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            HOLD: begin
                state_next     = RSP;
                rsp_valid_next = 1'b1;
                rsp_rdata_next = '0;
            end

            RSP: begin
                if (rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                end
            end

            default: begin
                state_next     = IDLE;
                cs_next        = 1'b0;
                wr_next        = 1'b0;
                rsp_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            we_reg        <= 1'b0;
            be_reg        <= '0;
            wdata_reg     <= '0;
            cs_reg        <= 1'b0;
            wr_reg        <= 1'b0;
            addr_reg      <= '0;
            din_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            we_reg        <= we_next;
            be_reg        <= be_next;
            wdata_reg     <= wdata_next;
            cs_reg        <= cs_next;
            wr_reg        <= wr_next;
            addr_reg      <= addr_next;
            din_reg       <= din_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign sram_cs   = cs_reg;
    assign sram_wr   = wr_reg;
    assign sram_addr = addr_reg;
    assign sram_din  = din_reg;

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomised scoreboard bench for sram_ctrl with a behavioural SRAM and word-level memory model.
module tb_sram_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int W     = 3;
    localparam int NRAND = 150;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [BW-1:0] req_be;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          sram_cs;
    logic          sram_wr;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    always #5 clk = ~clk;

    sram_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WAIT_CYCLES(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_be   (req_be),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .sram_cs  (sram_cs),
        .sram_wr  (sram_wr),
        .sram_addr(sram_addr),
        .sram_din (sram_din),
        .sram_dout(sram_dout)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        int            lat;
        int            cs;
        int            acc;
        logic [AW-1:0] addr;
        logic          we;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            last_hs = 0;
    logic          bp_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input int i);
        logic [DW-1:0] x;
        x = DW'(i);
        return (x * 32'h9E37_79B1) ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired t=%0t", name, $time);
    endtask

    // Asynchronous SRAM: combinational read, level-sensitive write sampled mid-cycle.
    assign sram_dout = sram_mem[sram_addr];
    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = init_word(i);
        sram_mem[10'h010] = 32'hDEAD_BEEF;
        sram_mem[10'h020] = 32'h1122_3344;
        forever begin
            @(negedge clk);
            if (sram_cs && sram_wr) sram_mem[sram_addr] = sram_din;
        end
    end

    // Consumer: random rsp_ready, or five held-off cycles of valid response in backpressure mode.
    int bp_held = 0;
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_mode) bp_held = 0;
            if (bp_mode && bp_held < 5) begin
                rsp_ready = 1'b0;
                if (rsp_valid) bp_held++;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: response scoreboard plus SRAM bus protocol checks.
    exp_t          mon_e;
    logic          pending = 1'b0;
    logic [DW-1:0] held_rdata = '0;
    int            cs_cnt = 0;
    int            wr_run = 0;
    int            n_rsp = 0;
    logic          prev_wr = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_din = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 1'b0;
                cs_cnt  = 0;
                wr_run  = 0;
                prev_wr = 1'b0;
                continue;
            end
            if (sram_cs) cs_cnt++;
            if (prev_wr) begin
                chk("addr_stable_wr", 64'(sram_addr), 64'(prev_addr));
                chk("din_stable_wr", 64'(sram_din), 64'(prev_din));
            end
            if (sram_wr) begin
                wr_run++;
                chk("cs_with_wr", 64'(sram_cs), 64'(1));
            end else if (prev_wr) begin
                chk("wr_pulse_len", 64'(wr_run), 64'(W));
                wr_run = 0;
            end
            prev_wr   = sram_wr;
            prev_addr = sram_addr;
            prev_din  = sram_din;

            if (rsp_valid) begin
                if (!pending) begin
                    if (sb.size() == 0) begin
                        timeout_fail("unexpected_rsp");
                    end else begin
                        mon_e = sb.pop_front();
                        chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                        chk("rsp_latency", 64'(cyc + 1 - mon_e.acc), 64'(mon_e.lat));
                        chk("cs_cycles", 64'(cs_cnt), 64'(mon_e.cs));
                        n_rsp++;
                        $display("rsp %0d: we=%0d addr=%03h rdata=%08h lat=%0d", n_rsp,
                                 mon_e.we, mon_e.addr, rsp_rdata, cyc + 1 - mon_e.acc);
                    end
                    held_rdata = rsp_rdata;
                    pending    = 1'b1;
                    cs_cnt     = 0;
                end else begin
                    chk("rdata_stable", 64'(rsp_rdata), 64'(held_rdata));
                end
                chk("req_ready_low", 64'(req_ready), 64'(0));
                if (rsp_ready) begin
                    pending = 1'b0;
                    last_hs = cyc + 1;
                end
            end else if (pending) begin
                timeout_fail("rsp_dropped");
                pending = 1'b0;
            end
        end
    end

    // Issue one request, wait for acceptance and push the model's expected response.
    task automatic issue(input logic we, input logic [BW-1:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            timeout_fail("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        e.acc  = cyc + 1;
        e.addr = addr;
        e.we   = we;
        chk("accept_after_rsp", 64'(e.acc > last_hs), 64'(1));
        if (!we) begin
            e.rdata = ref_mem[addr];
            e.lat   = W + 1;
            e.cs    = W;
        end else if (be == '0) begin
            e.rdata = '0;
            e.lat   = 1;
            e.cs    = 0;
        end else if (be == {BW{1'b1}}) begin
            ref_mem[addr] = wdata;
            e.rdata = '0;
            e.lat   = W + 2;
            e.cs    = W;
        end else begin
            for (int b = 0; b < BW; b++)
                if (be[b]) ref_mem[addr][8*b +: 8] = wdata[8*b +: 8];
            e.rdata = '0;
            e.lat   = 2 * W + 2;
            e.cs    = 2 * W;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = AW'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || rsp_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) timeout_fail("drain_timeout");
    endtask

    initial begin
        logic          r_we;
        logic [BW-1:0] r_be;
        logic [AW-1:0] r_addr;
        int            sel;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        ref_mem[10'h010] = 32'hDEAD_BEEF;
        ref_mem[10'h020] = 32'h1122_3344;

        #2;
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_sram_cs", 64'(sram_cs), 64'(0));
        chk("rst_sram_wr", 64'(sram_wr), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_sram_addr", 64'(sram_addr), 64'(0));
        chk("rst_sram_din", 64'(sram_din), 64'(0));
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        issue(1'b0, 4'h0, 10'h010, 32'h0);
        issue(1'b1, 4'hF, 10'h3FF, 32'hCAFE_F00D);
        issue(1'b0, 4'h0, 10'h3FF, 32'h0);
        issue(1'b1, 4'b0101, 10'h020, 32'hAABB_CCDD);
        issue(1'b0, 4'h0, 10'h020, 32'h0);
        issue(1'b1, 4'h0, 10'h010, 32'h1234_5678);
        issue(1'b0, 4'h0, 10'h010, 32'h0);
        drain();

        bp_mode = 1'b1;
        issue(1'b0, 4'h0, 10'h3FF, 32'h0);
        issue(1'b0, 4'h0, 10'h020, 32'h0);
        drain();
        bp_mode = 1'b0;

        // Abort a read while it is in RD.
        issue(1'b0, 4'h0, 10'h011, 32'h0);
        @(negedge clk);
        chk("cs_in_rd", 64'(sram_cs), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs", 64'(sram_cs), 64'(0));
        chk("abort_wr", 64'(sram_wr), 64'(0));
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", 64'(req_ready), 64'(1));
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        repeat (8) @(negedge clk);

        for (int n = 0; n < NRAND; n++) begin
            r_we = 1'($urandom_range(0, 1));
            sel  = $urandom_range(0, 3);
            r_be = (sel == 0) ? '0 : (sel == 1) ? {BW{1'b1}} : BW'($urandom);
            r_addr = ($urandom_range(0, 7) == 0) ? 10'h3FF : AW'($urandom_range(0, 31));
            issue(r_we, r_be, r_addr, $urandom);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
